interfaz_teclado_cajero: RTL and testbench
==========================================

Name: interfaz_teclado_cajero

Overview:
Keypad front-end that drives the Cajero input protocol from the customer side. It converts raw key presses into the DIGITO/DIGITO_STB PIN stream, TIPO_TRANS, and a decimal-assembled MONTO with a single-cycle MONTO_STB. It tracks Cajero status outputs to know when to restart, abort, or accept a new transaction. It sits between the physical keypad decoder and Cajero in the system top.

Parameters:
PIN_LEN, 4, PIN digits forwarded before leaving the PIN phase.
MAX_DIG_MONTO, 9, maximum decimal digits accepted for MONTO; 999999999 < 2^32.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  synchronous, active-high reset.
TARJETA_RECIBIDA  in  1  level; card present.
TECLA_STB  in  1  one-cycle pulse per key press.
TECLA  in  4  key code: 0-9 digit, 0xA ENTER, 0xB BORRAR, 0xC DEPOSITO, 0xD RETIRO, 0xE/0xF invalid.
PIN_INCORRECTO  in  1  from Cajero.
BLOQUEO  in  1  from Cajero.
BALANCE_STB  in  1  from Cajero; transaction done.
FONDOS_INSUFICIENTES  in  1  from Cajero; withdrawal rejected.
DIGITO  out  4  PIN digit to Cajero.
DIGITO_STB  out  1  one-cycle strobe qualifying DIGITO.
TIPO_TRANS  out  1  0 = deposit, 1 = withdrawal.
MONTO  out  32  assembled amount.
MONTO_STB  out  1  one-cycle strobe qualifying MONTO.
ERROR_TECLA  out  1  one-cycle pulse on a rejected key.
estado_tx  out  3  current state, for debug.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. On reset, every output is 0, the state is ESPERA_TARJETA, and the counters and accumulator are 0.
- Output timing: all outputs are registered. A response to a key appears in the cycle after its TECLA_STB. Only TECLA_STB cycles are evaluated.
- ESPERA_TARJETA (0): keys are ignored and no error is raised. TARJETA_RECIBIDA=1 moves to ENVIO_PIN with cont_pin=0.
- ENVIO_PIN (1):
  - A key 0-9 sets DIGITO<=TECLA and pulses DIGITO_STB for one cycle, then cont_pin++.
  - When cont_pin reaches PIN_LEN, go to SELECCION.
  - Any other key pulses ERROR_TECLA; cont_pin is unchanged.
- SELECCION (3):
  - 0xC sets TIPO_TRANS<=0; 0xD sets TIPO_TRANS<=1.
  - Either one moves to CAPTURA_MONTO and clears acc and ndig.
  - Any other key pulses ERROR_TECLA.
- CAPTURA_MONTO (4):
  - Digit with ndig<MAX_DIG_MONTO: acc<=acc*10+d (computed as (acc<<3)+(acc<<1)+d, 32-bit), ndig++.
  - Digit with ndig=MAX_DIG_MONTO: ERROR_TECLA pulses; acc is unchanged.
  - 0xB: acc<=0, ndig<=0.
  - 0xA with ndig=0: ERROR_TECLA pulses; stay.
  - 0xA with ndig>0: go to ENVIO_MONTO.
  - Other keys: ERROR_TECLA pulses.
- ENVIO_MONTO (5):
  - Lasts exactly one cycle: MONTO<=acc, then MONTO_STB=1 in the following cycle.
  - Goes to ESPERA_RESULTADO.
- ESPERA_RESULTADO (6):
  - Keys are ignored, no error.
  - BALANCE_STB or FONDOS_INSUFICIENTES moves to SELECCION.
- Hold rules: MONTO holds until the next MONTO_STB load. DIGITO holds its last value. TIPO_TRANS holds until the next selection.
- Global aborts, checked in every state except ESPERA_TARJETA, highest priority first:
  - RESET.
  - BLOQUEO=1 or TARJETA_RECIBIDA=0: go to ESPERA_TARJETA and clear counters and acc.
  - PIN_INCORRECTO=1: go to ENVIO_PIN with cont_pin=0 and acc=0.
- Simultaneous events: an abort wins over a same-cycle TECLA_STB; the key is dropped with no ERROR_TECLA. Strobes never assert in the cycle an abort is taken.
- Reset mid-PIN or mid-amount discards all partial input.

Decomposition:
- Package cajero_pkg: state encodings (3-bit), key-code constants (TECLA_ENTER=4'hA, TECLA_BORRAR=4'hB, TECLA_DEPOSITO=4'hC, TECLA_RETIRO=4'hD), and the PIN_LEN default.
- Sub-module acumulador_decimal: holds the 32-bit acc and the ndig counter, with clear/load-digit controls and a lleno flag at MAX_DIG_MONTO.

Test Plan:
- PIN forwarding: card in, then keys 1,2,3,4 → four DIGITO_STB pulses carrying DIGITO=1,2,3,4, each one cycle after its key; estado_tx=3 after the 4th.
- Withdrawal amount: 0xD then 5,0,0,0xA → TIPO_TRANS=1 and MONTO_STB one cycle with MONTO=500. BALANCE_STB then returns estado_tx=3.
- Amount edge keys: 0xA with no digits → ERROR_TECLA, no MONTO_STB. Ten 9s → 10th key gives ERROR_TECLA; ENTER gives MONTO=999999999.
- Clear: 0xC, 7,7,0xB,3,0xA → TIPO_TRANS=0, MONTO=3.
- Aborts: PIN_INCORRECTO during CAPTURA_MONTO → state 1, acc=0. BLOQUEO coinciding with TECLA_STB → state 0, no ERROR_TECLA, no strobe.
- Reset: RESET=1 while in ESPERA_RESULTADO → all outputs 0 next cycle, estado_tx=0.

Source files
------------

// File: rtl/cajero_pkg.sv
// Shared definitions for the keypad front-end of the Cajero:
// state encodings, key codes and default sizing.
package cajero_pkg;

  localparam int PIN_LEN_DEF       = 4;
  localparam int MAX_DIG_MONTO_DEF = 9;

  localparam logic [3:0] TECLA_ENTER    = 4'hA;
  localparam logic [3:0] TECLA_BORRAR   = 4'hB;
  localparam logic [3:0] TECLA_DEPOSITO = 4'hC;
  localparam logic [3:0] TECLA_RETIRO   = 4'hD;

  // Encodings are visible on estado_tx, so values are fixed, not sequential.
  typedef enum logic [2:0] {
    ESPERA_TARJETA   = 3'd0,
    ENVIO_PIN        = 3'd1,
    SELECCION        = 3'd3,
    CAPTURA_MONTO    = 3'd4,
    ENVIO_MONTO      = 3'd5,
    ESPERA_RESULTADO = 3'd6
  } estado_t;

  function automatic logic es_digito(input logic [3:0] tecla);
    return tecla <= 4'd9;
  endfunction

endpackage

// File: rtl/acumulador_decimal.sv
// Decimal amount accumulator: acc = acc*10 + d per accepted digit,
// with a digit counter that saturates at MAX_DIG.
module acumulador_decimal #(
  parameter int MAX_DIG = 9
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        clr_i,
  input  logic        cargar_i,
  input  logic [3:0]  digito_i,
  output logic [31:0] acc_o,
  output logic        lleno_o,
  output logic        vacio_o
);

  localparam int NW = $clog2(MAX_DIG + 1);

  logic [31:0]   acc_q, acc_d;
  logic [NW-1:0] ndig_q, ndig_d;

  assign lleno_o = (ndig_q == NW'(MAX_DIG));
  assign vacio_o = (ndig_q == '0);
  assign acc_o   = acc_q;

  always_comb begin
    acc_d  = acc_q;
    ndig_d = ndig_q;
    if (clr_i) begin
      acc_d  = '0;
      ndig_d = '0;
    end else if (cargar_i && !lleno_o) begin
      // x10 as two shifts and an add keeps this out of a multiplier.
      acc_d  = (acc_q << 3) + (acc_q << 1) + {28'd0, digito_i};
      ndig_d = ndig_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q  <= '0;
      ndig_q <= '0;
    end else begin
      acc_q  <= acc_d;
      ndig_q <= ndig_d;
    end
  end

endmodule

// File: rtl/interfaz_teclado_cajero.sv
// Keypad front-end for the Cajero: forwards PIN digits, captures the
// transaction type and a decimal amount, and follows Cajero status.
module interfaz_teclado_cajero
  import cajero_pkg::*;
#(
  parameter int PIN_LEN       = PIN_LEN_DEF,
  parameter int MAX_DIG_MONTO = MAX_DIG_MONTO_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TARJETA_RECIBIDA,
  input  logic        TECLA_STB,
  input  logic [3:0]  TECLA,
  input  logic        PIN_INCORRECTO,
  input  logic        BLOQUEO,
  input  logic        BALANCE_STB,
  input  logic        FONDOS_INSUFICIENTES,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic        TIPO_TRANS,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic        ERROR_TECLA,
  output logic [2:0]  estado_tx
);

  localparam int CW = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
  localparam logic [CW-1:0] ULTIMO_PIN = CW'(PIN_LEN - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [3:0]    digito_q, digito_d;
  logic          dstb_q, dstb_d;
  logic          tipo_q, tipo_d;
  logic [31:0]   monto_q, monto_d;
  logic          mstb_q, mstb_d;
  logic          err_q, err_d;

  logic          acc_clr, acc_cargar, acc_lleno, acc_vacio;
  logic [31:0]   acc;

  acumulador_decimal #(.MAX_DIG(MAX_DIG_MONTO)) u_acc (
    .clk      (CLK),
    .srst     (RESET),
    .clr_i    (acc_clr),
    .cargar_i (acc_cargar),
    .digito_i (TECLA),
    .acc_o    (acc),
    .lleno_o  (acc_lleno),
    .vacio_o  (acc_vacio)
  );

  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    digito_d   = digito_q;
    dstb_d     = 1'b0;
    tipo_d     = tipo_q;
    monto_d    = monto_q;
    mstb_d     = 1'b0;
    err_d      = 1'b0;
    acc_clr    = 1'b0;
    acc_cargar = 1'b0;

    case (estado_q)
      ESPERA_TARJETA: begin
        if (TARJETA_RECIBIDA) begin
          estado_d = ENVIO_PIN;
          cont_d   = '0;
        end
      end
      default: begin
        // Aborts pre-empt any key pressed in the same cycle.
        if (BLOQUEO || !TARJETA_RECIBIDA) begin
          estado_d = ESPERA_TARJETA;
          cont_d   = '0;
          acc_clr  = 1'b1;
        end else if (PIN_INCORRECTO) begin
          estado_d = ENVIO_PIN;
          cont_d   = '0;
          acc_clr  = 1'b1;
        end else begin
          case (estado_q)
            ENVIO_PIN: begin
              if (TECLA_STB) begin
                if (es_digito(TECLA)) begin
                  digito_d = TECLA;
                  dstb_d   = 1'b1;
                  if (cont_q == ULTIMO_PIN) begin
                    estado_d = SELECCION;
                    cont_d   = '0;
                  end else begin
                    cont_d = cont_q + 1'b1;
                  end
                end else begin
                  err_d = 1'b1;
                end
              end
            end
            SELECCION: begin
              if (TECLA_STB) begin
                if (TECLA == TECLA_DEPOSITO || TECLA == TECLA_RETIRO) begin
                  tipo_d   = (TECLA == TECLA_RETIRO);
                  estado_d = CAPTURA_MONTO;
                  acc_clr  = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
            end
            CAPTURA_MONTO: begin
              if (TECLA_STB) begin
                if (es_digito(TECLA)) begin
                  if (acc_lleno) err_d = 1'b1;
                  else           acc_cargar = 1'b1;
                end else if (TECLA == TECLA_BORRAR) begin
                  acc_clr = 1'b1;
                end else if (TECLA == TECLA_ENTER) begin
                  if (acc_vacio) err_d = 1'b1;
                  else           estado_d = ENVIO_MONTO;
                end else begin
                  err_d = 1'b1;
                end
              end
            end
            ENVIO_MONTO: begin
              monto_d  = acc;
              mstb_d   = 1'b1;
              estado_d = ESPERA_RESULTADO;
            end
            ESPERA_RESULTADO: begin
              if (BALANCE_STB || FONDOS_INSUFICIENTES) estado_d = SELECCION;
            end
            default: estado_d = ESPERA_TARJETA;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado_q <= ESPERA_TARJETA;
      cont_q   <= '0;
      digito_q <= '0;
      dstb_q   <= 1'b0;
      tipo_q   <= 1'b0;
      monto_q  <= '0;
      mstb_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      digito_q <= digito_d;
      dstb_q   <= dstb_d;
      tipo_q   <= tipo_d;
      monto_q  <= monto_d;
      mstb_q   <= mstb_d;
      err_q    <= err_d;
    end
  end

  assign DIGITO      = digito_q;
  assign DIGITO_STB  = dstb_q;
  assign TIPO_TRANS  = tipo_q;
  assign MONTO       = monto_q;
  assign MONTO_STB   = mstb_q;
  assign ERROR_TECLA = err_q;
  assign estado_tx   = estado_q;

endmodule

// File: tb/tb_interfaz_teclado_cajero.sv
// Bench for interfaz_teclado_cajero: directed scenarios then biased random
// traffic, every output compared each cycle against a behavioural model.
module tb_interfaz_teclado_cajero;

  logic        CLK = 1'b0;
  logic        RESET, TARJETA_RECIBIDA, TECLA_STB, PIN_INCORRECTO, BLOQUEO;
  logic        BALANCE_STB, FONDOS_INSUFICIENTES;
  logic [3:0]  TECLA;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB, TIPO_TRANS, MONTO_STB, ERROR_TECLA;
  logic [31:0] MONTO;
  logic [2:0]  estado_tx;

  interfaz_teclado_cajero dut (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
    .TECLA_STB(TECLA_STB), .TECLA(TECLA), .PIN_INCORRECTO(PIN_INCORRECTO),
    .BLOQUEO(BLOQUEO), .BALANCE_STB(BALANCE_STB),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .DIGITO(DIGITO),
    .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO),
    .MONTO_STB(MONTO_STB), .ERROR_TECLA(ERROR_TECLA), .estado_tx(estado_tx)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  bit have_exp = 0;

  // Reference model: phase per the documented state numbers, amount as an integer.
  int     m_st, m_cont, m_nd;
  longint m_amt;
  logic [3:0]  e_dig;
  logic        e_dstb, e_tipo, e_mstb, e_err;
  logic [31:0] e_monto;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    chk("estado", {29'd0, estado_tx}, m_st[31:0]);
    chk("digito", {28'd0, DIGITO}, {28'd0, e_dig});
    chk("digito_stb", {31'd0, DIGITO_STB}, {31'd0, e_dstb});
    chk("tipo", {31'd0, TIPO_TRANS}, {31'd0, e_tipo});
    chk("monto", MONTO, e_monto);
    chk("monto_stb", {31'd0, MONTO_STB}, {31'd0, e_mstb});
    chk("error", {31'd0, ERROR_TECLA}, {31'd0, e_err});
    if (e_mstb) $display("tx tipo=%0d monto=%0d", e_tipo, e_monto);
  endtask

  task automatic model(input logic rst, tar, stb, input logic [3:0] k,
                       input logic pinc, bloq, bal, fon);
    e_dstb = 0; e_mstb = 0; e_err = 0;
    if (rst) begin
      m_st = 0; m_cont = 0; m_amt = 0; m_nd = 0;
      e_dig = 0; e_tipo = 0; e_monto = 0;
    end else if (m_st == 0) begin
      if (tar) begin m_st = 1; m_cont = 0; end
    end else if (bloq || !tar) begin
      m_st = 0; m_cont = 0; m_amt = 0; m_nd = 0;
    end else if (pinc) begin
      m_st = 1; m_cont = 0; m_amt = 0; m_nd = 0;
    end else begin
      case (m_st)
        1: if (stb) begin
             if (k <= 9) begin
               e_dig = k; e_dstb = 1; m_cont++;
               if (m_cont == 4) begin m_st = 3; m_cont = 0; end
             end else e_err = 1;
           end
        3: if (stb) begin
             if (k == 4'hC || k == 4'hD) begin
               e_tipo = (k == 4'hD); m_st = 4; m_amt = 0; m_nd = 0;
             end else e_err = 1;
           end
        4: if (stb) begin
             if (k <= 9) begin
               if (m_nd < 9) begin m_amt = m_amt * 10 + longint'(k); m_nd++; end
               else e_err = 1;
             end else if (k == 4'hB) begin
               m_amt = 0; m_nd = 0;
             end else if (k == 4'hA) begin
               if (m_nd == 0) e_err = 1; else m_st = 5;
             end else e_err = 1;
           end
        5: begin e_monto = m_amt[31:0]; e_mstb = 1; m_st = 6; end
        6: if (bal || fon) m_st = 3;
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic cycle(input logic rst, tar, stb, input logic [3:0] k,
                       input logic pinc, bloq, bal, fon);
    @(negedge CLK);
    if (have_exp) check_all();
    RESET = rst; TARJETA_RECIBIDA = tar; TECLA_STB = stb; TECLA = k;
    PIN_INCORRECTO = pinc; BLOQUEO = bloq; BALANCE_STB = bal;
    FONDOS_INSUFICIENTES = fon;
    model(rst, tar, stb, k, pinc, bloq, bal, fon);
    have_exp = 1;
  endtask

  task automatic key(input logic [3:0] k);
    cycle(0, 1, 1, k, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 4'h0, 0, 0, 0, 0);
  endtask

  initial begin
    RESET = 1; TARJETA_RECIBIDA = 0; TECLA_STB = 0; TECLA = 0;
    PIN_INCORRECTO = 0; BLOQUEO = 0; BALANCE_STB = 0; FONDOS_INSUFICIENTES = 0;
    cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    cycle(0, 0, 1, 4'h5, 0, 0, 0, 0);       // key with no card: ignored
    idle(1);
    key(4'h1); key(4'h2); key(4'hE); key(4'h3); key(4'h4);
    key(4'h7);                                // error in SELECCION
    key(4'hD); key(4'h5); key(4'h0); key(4'h0); key(4'hA);
    idle(3);
    cycle(0, 1, 1, 4'h3, 0, 0, 1, 0);       // BALANCE_STB, key ignored
    key(4'hC); key(4'hA);                     // ENTER with no digits
    for (int i = 0; i < 10; i++) key(4'h9);
    key(4'hA);
    idle(3);
    cycle(0, 1, 0, 4'h0, 0, 0, 0, 1);
    key(4'hC); key(4'h7); key(4'h7); key(4'hB); key(4'h3); key(4'hA);
    idle(3);
    cycle(0, 1, 0, 4'h0, 0, 0, 1, 0);
    key(4'hD); key(4'h5);
    cycle(0, 1, 1, 4'h6, 1, 0, 0, 0);       // PIN_INCORRECTO mid-amount
    key(4'h8); key(4'h8); key(4'h8); key(4'h8);
    key(4'hD); key(4'hA);                     // acc must be empty again
    key(4'h4);
    cycle(0, 1, 1, 4'hF, 0, 1, 0, 0);       // BLOQUEO with a bad key
    idle(2);
    key(4'h1); key(4'h1); key(4'h1); key(4'h1);
    key(4'hD); key(4'h2); key(4'hA);
    idle(2);
    cycle(1, 1, 1, 4'h3, 0, 0, 0, 0);       // reset in ESPERA_RESULTADO
    idle(2);

    for (int n = 0; n < 4000; n++) begin
      logic rst, tar, stb, pinc, bloq, bal, fon;
      logic [3:0] k;
      int r;
      r    = int'($urandom_range(99));
      rst  = ($urandom_range(599) == 0);
      tar  = (m_st == 0) ? ($urandom_range(99) < 30) : ($urandom_range(199) != 0);
      bloq = ($urandom_range(299) == 0);
      pinc = ($urandom_range(199) == 0);
      bal  = (m_st == 6) ? ($urandom_range(99) < 15) : ($urandom_range(99) < 2);
      fon  = (m_st == 6) ? ($urandom_range(99) < 10) : ($urandom_range(99) < 2);
      stb  = ($urandom_range(99) < 60);
      k    = 4'($urandom_range(15));
      if (m_st == 1 && r < 85) k = 4'($urandom_range(9));
      if (m_st == 3 && r < 60) k = (r < 30) ? 4'hC : 4'hD;
      if (m_st == 4) begin
        if (r < 72)      k = 4'($urandom_range(9));
        else if (r < 85) k = 4'hA;
        else if (r < 90) k = 4'hB;
      end
      cycle(rst, tar, stb, k, pinc, bloq, bal, fon);
    end
    @(negedge CLK);
    check_all();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
